mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving storage size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter WAIT, default 2, range 0-3, giving wait-state cycles inserted before each response.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port Req, input, 1 bit: request strobe from initiator, sampled only in IDLE.
REQ-006 The block SHALL have port Wr, input, 1 bit: 1 = write, 0 = read; sampled with Req.
REQ-007 The block SHALL have port Size, input, 2 bits: 00 word, 01 halfword, 10 byte, 11 reserved (error).
REQ-008 The block SHALL have port Address, input, 32 bits: byte address; sampled with Req.
REQ-009 The block SHALL have port Datain, input, 32 bits: write data, right-justified for byte/half; sampled with Req.
REQ-010 The block SHALL have port Dataout, output, 32 bits: full aligned word read data, valid only while Ack=1 on a read.
REQ-011 The block SHALL have port Ack, output, 1 bit: one-cycle response pulse.
REQ-012 The block SHALL have port Busy, output, 1 bit: 1 in every state except IDLE.
REQ-013 The block SHALL have port AddrErr, output, 1 bit: qualified by Ack; flags misaligned access or Size=11.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; transitions IDLE->WAIT (Req=1, WAIT>0), IDLE->RESP (Req=1, WAIT=0), WAIT->RESP when the wait counter reaches WAIT-1, RESP->IDLE unconditionally.
REQ-015 On acceptance, Wr, Size, Address, Datain SHALL be latched; later input changes SHALL NOT affect the transaction.
REQ-016 Ack SHALL be 1 exactly during the RESP cycle, i.e. WAIT+1 cycles after the accepting edge.
REQ-017 Req while Busy=1 SHALL be ignored, not queued; a Req held high through RESP SHALL be accepted again on the first IDLE cycle (minimum one IDLE cycle between transactions).
REQ-018 The word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-019 Byte lanes SHALL be little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24.
REQ-020 A word write SHALL update all four lanes; a halfword write SHALL update lanes {off+1,off} with Datain[15:0]; a byte write SHALL update lane off with Datain[7:0]; other lanes SHALL be unchanged.
REQ-021 The write SHALL commit at the end of the RESP cycle.
REQ-022 A read SHALL drive Dataout with the whole addressed word regardless of Size; Dataout SHALL be 0 whenever Ack=0 or the request is a write.
REQ-023 Misalignment SHALL be: word with Address[1:0]!=0, half with Address[0]=1; misaligned or Size=11 SHALL give Ack=1, AddrErr=1, no memory write, Dataout=0.
REQ-024 The wait counter SHALL be 2 bits and reset to 0 on each acceptance.

Reset
REQ-025 Reset=0 at a clock edge SHALL force state IDLE, counter 0, Ack=0, Busy=0, AddrErr=0, Dataout=0, regardless of current state.
REQ-026 Reset mid-transaction SHALL abort it with no Ack and no memory write.
REQ-027 Storage contents SHALL be preserved across reset and SHALL be all-zero at power-up.
REQ-028 Req asserted in the same cycle as Reset=0 SHALL be discarded.

Verification
REQ-029 WAIT=2: write word 0xDEADBEEF to 0x10, then read 0x10 -> Ack at accept+3 cycles each, Dataout=0xDEADBEEF, AddrErr=0.
REQ-030 Byte write 0x000000AA to 0x11 over 0xDEADBEEF, then half write 0x1234 to 0x12 -> read 0x10 returns 0x1234AAEF.
REQ-031 Word read at 0x13 and half write at 0x11 -> Ack=1, AddrErr=1, Dataout=0, word at 0x10 unchanged.
REQ-032 DEPTH_WORDS=256: write 0x55 word to 0x400, read 0x0 -> 0x00000055 (wrap).
REQ-033 Reset=0 during WAIT of a write -> no Ack, Busy=0 next cycle, target word unchanged; read after reset returns prior contents.
REQ-034 WAIT=0 with Req held high for 6 cycles -> Ack on cycles 2, 4, 6 (alternating RESP/IDLE), changed inputs in between ignored.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a Req/Ack initiator handshake, with a fixed
// number of wait states before each one-cycle response. Byte, halfword and word access.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT        = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic [31:0] Address,
  input  logic [31:0] Datain,
  output logic [31:0] Dataout,
  output logic        Ack,
  output logic        Busy,
  output logic        AddrErr,
  output logic [1:0]  state_dbg
);

  // Handshake: Req is sampled only in IDLE (Req while Busy is dropped, not queued);
  // Ack is a one-cycle pulse WAIT+1 cycles after the accepting edge, and
  // AddrErr/Dataout are meaningful only while Ack is high.

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] WAIT_LAST = (WAIT == 0) ? 2'd0 : 2'(WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [1:0]     size_q, size_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic [31:0]    din_q, din_d;
  logic           ack_q, ack_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [31:0]    dout_q, dout_d;
  logic           txn_err;

  logic [31:0]    mem_q [DEPTH_WORDS];
  logic           mem_we;
  logic [31:0]    mem_wdata;

  // Address bits above the word index wrap and are intentionally ignored.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^Address[31:AW+2];

  function automatic logic addr_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return off != 2'b00;
      2'b01:   return off[0];
      2'b10:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          wr_d    = Wr;
          size_d  = Size;
          addr_d  = Address[AW+1:0];
          din_d   = Datain;
          cnt_d   = 2'd0;
          state_d = (WAIT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_RESP;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The *_d transaction fields already hold the accepted request, even when
    // IDLE jumps straight to RESP, so the response can be registered from them.
    txn_err = addr_err(size_d, addr_d[1:0]);
    ack_d   = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
    err_d   = ack_d && txn_err;
    dout_d  = (ack_d && !wr_d && !txn_err) ? mem_q[addr_d[AW+1:2]] : 32'd0;
  end

  always_comb begin
    mem_wdata = mem_q[addr_q[AW+1:2]];
    case (size_q)
      2'b00: mem_wdata = din_q;
      2'b01: begin
        if (addr_q[1]) mem_wdata[31:16] = din_q[15:0];
        else           mem_wdata[15:0]  = din_q[15:0];
      end
      2'b10: begin
        case (addr_q[1:0])
          2'd0:    mem_wdata[7:0]   = din_q[7:0];
          2'd1:    mem_wdata[15:8]  = din_q[7:0];
          2'd2:    mem_wdata[23:16] = din_q[7:0];
          default: mem_wdata[31:24] = din_q[7:0];
        endcase
      end
      default: ;
    endcase
    // Commit at the end of RESP; a reset on that edge aborts the write.
    mem_we = (state_q == S_RESP) && wr_q && !addr_err(size_q, addr_q[1:0]) && Reset;
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[addr_q[AW+1:2]] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign Ack       = ack_q;
  assign Busy      = busy_q;
  assign AddrErr   = err_q;
  assign Dataout   = dout_q;
  assign state_dbg = state_q;

endmodule
